// File: rtl/pmod_pkg.sv
// Shared definitions for the PMOD ADC/DAC serial links: FSM states, frame geometry
// and the leading-zero check on a received ADC frame.
package pmod_pkg;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_BITS  = 12;
  localparam int unsigned ADC_LEAD_ZEROS = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE,
    QUIET
  } adc_state_e;

  // A well-formed AD7476A frame starts with ADC_LEAD_ZEROS zero bits.
  function automatic logic lead_err(input logic [ADC_FRAME_BITS-1:0] frame);
    return |frame[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS];
  endfunction

endpackage

// File: rtl/pmod_sclk_gen.sv
// SPI clock generator: DIV clk cycles per SCLK half-period while enabled, idles high.
// rise_o/fall_o flag the clk cycle whose closing edge drives SCLK 0->1 / 1->0.
module pmod_sclk_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;
  logic       tick;

  always_comb begin
    tick   = en_i && (cnt_q == LAST);
    cnt_d  = '0;
    sclk_d = 1'b1;
    if (en_i) begin
      cnt_d  = tick ? '0 : cnt_q + 8'd1;
      sclk_d = tick ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;
  assign rise_o = tick & ~sclk_q;
  assign fall_o = tick & sclk_q;

endmodule

// File: rtl/pmod_adc_rx_block.sv
// Receiver for a dual AD7476A PMOD: drives CS_n/SCLK, shifts in one 16-bit frame per
// channel and presents both 12-bit samples with a one-cycle valid strobe.
module pmod_adc_rx_block
  import pmod_pkg::*;
#(
  parameter int unsigned SCLK_DIV     = 4,
  parameter int unsigned QUIET_CYCLES = 8,
  parameter bit          CONTINUOUS   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     adc_sdata0,
  input  logic                     adc_sdata1,
  output logic                     adc_cs_n,
  output logic                     adc_sclk,
  output logic [ADC_DATA_BITS-1:0] data0,
  output logic [ADC_DATA_BITS-1:0] data1,
  output logic                     valid,
  output logic                     frame_err,
  output logic                     busy
);

  localparam logic [7:0] SETUP_LAST = 8'(SCLK_DIV - 1);
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);
  localparam logic [3:0] LAST_BIT   = 4'(ADC_FRAME_BITS - 1);

  adc_state_e                state_q, state_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [3:0]                bit_q, bit_d;
  logic [ADC_FRAME_BITS-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [ADC_DATA_BITS-1:0]  data0_q, data1_q;
  logic                      cs_n_q, busy_q, valid_q, ferr_q;
  logic                      sclk_en, sclk_rise, sclk_fall_unused;

  assign sclk_en = (state_q == SHIFT);

  pmod_sclk_gen #(.DIV(SCLK_DIV)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .en_i   (sclk_en),
    .sclk_o (adc_sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall_unused)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start || CONTINUOUS) state_d = SETUP;
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          sh0_d = {sh0_q[ADC_FRAME_BITS-2:0], adc_sdata0};
          sh1_d = {sh1_q[ADC_FRAME_BITS-2:0], adc_sdata1};
          bit_d = bit_q + 4'd1;
          if (bit_q == LAST_BIT) state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = QUIET;
      end
      QUIET: begin
        if (cnt_q == QUIET_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin-level outputs are registered decodes of the current state, so they trail
  // the state register by one clk; SCLK comes straight from its own register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      cs_n_q  <= !((state_q == SETUP) || (state_q == SHIFT));
      busy_q  <= (state_q != IDLE);
      valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        data0_q <= sh0_q[ADC_DATA_BITS-1:0];
        data1_q <= sh1_q[ADC_DATA_BITS-1:0];
        ferr_q  <= lead_err(sh0_q) | lead_err(sh1_q);
      end
    end
  end

  assign adc_cs_n  = cs_n_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign data0     = data0_q;
  assign data1     = data1_q;

endmodule

// File: doc/pmod_adc_rx_block.md
Name: pmod_adc_rx_block

Overview:
- SPI receiver for a PMOD dual-channel 12-bit ADC (two AD7476A-class converters sharing CS_n/SCLK, separate SDATA lines).
- Paired opposite-direction block to the PMOD DAC transmitter. Together they form the analog I/O path of the neuromorphic ASIC bridge.
- Generates CS_n/SCLK, shifts in one 16-bit frame per channel, and presents two 12-bit samples with a one-cycle valid strobe.
- Conversions are triggered by a start pulse or run back-to-back in continuous mode.

Parameters:
- SCLK_DIV, 4, clk cycles per SCLK half-period (legal range 1..255).
- QUIET_CYCLES, 8, clk cycles CS_n is held high after a frame before the next start is accepted (legal range 1..255).
- CONTINUOUS, 0, when 1, a new frame starts automatically after the quiet period, without start.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request for one conversion; sampled only in IDLE
- adc_sdata0  in  1  serial data, channel 0 (ADC updates it on SCLK falling edge)
- adc_sdata1  in  1  serial data, channel 1
- adc_cs_n  out  1  chip select, active low
- adc_sclk  out  1  serial clock, idles high
- data0  out  12  last channel-0 sample
- data1  out  12  last channel-1 sample
- valid  out  1  one-cycle strobe; data0/data1 updated this cycle
- frame_err  out  1  sticky; a leading-zero bit was 1 in the last frame
- busy  out  1  high from start acceptance until the quiet period ends

Behaviour:
- Reset values, applied asynchronously: adc_cs_n=1, adc_sclk=1, data0=0, data1=0, valid=0, frame_err=0, busy=0, state=IDLE, all counters=0.
- Reset mid-frame aborts the frame immediately; no valid is produced.
- IDLE:
  - CS_n=1, SCLK=1, busy=0.
  - start=1 (or CONTINUOUS=1) → SETUP.
- SETUP:
  - CS_n=0, SCLK=1, busy=1.
  - Lasts SCLK_DIV cycles → SHIFT.
- SHIFT:
  - Divider counts 0..SCLK_DIV-1; SCLK toggles when the count reaches SCLK_DIV-1.
  - The first toggle is a falling edge.
  - On each clk edge that drives SCLK 0→1, adc_sdata0/1 are sampled into two 16-bit shift registers, MSB first.
  - The bit counter increments per rising edge.
  - After the 16th rising edge (32*SCLK_DIV cycles in SHIFT), SCLK remains high → DONE.
- DONE (1 cycle):
  - CS_n=1.
  - data0/data1 = shift[11:0]; valid=1.
  - frame_err=1 if shift[15:12]≠0 on either channel, else 0 (updated every frame, holds between frames).
  - → QUIET.
- QUIET:
  - CS_n=1, busy=1.
  - Lasts QUIET_CYCLES cycles → IDLE.
- Latency: with start seen at clk edge N, CS_n falls after edge N+1, and valid is high in the cycle after edge N+1+33*SCLK_DIV.
  - For SCLK_DIV=4: valid at edge N+133.
- start while busy is ignored; there is no queueing.
- start held high with CONTINUOUS=0 retriggers each time IDLE is reached.
- data0/data1 hold their value between valid strobes.
- Minimum frame period: 2 + 33*SCLK_DIV + QUIET_CYCLES clk cycles.

Decomposition:
- Shared package (pmod_pkg) holds:
  - state encoding localparams: IDLE, SETUP, SHIFT, DONE, QUIET
  - ADC_FRAME_BITS=16
  - ADC_DATA_BITS=12
  - ADC_LEAD_ZEROS=4
- One natural sub-module: pmod_sclk_gen (divider plus SCLK toggle, emitting rise/fall strobes). Make it reusable by the DAC transmitter.

Test Plan:
- Bench ADC model drives SDATA on SCLK falling edges. Frame ch0=0x0ABC, ch1=0x0123, SCLK_DIV=4, start pulse → valid once, 133 cycles after start; data0=0xABC, data1=0x123, frame_err=0; exactly 16 SCLK rising edges while CS_n=0.
- Frames 0x0FFF / 0x0000 (full-scale / zero) → data0=0xFFF, data1=0x000, no bit slip at the MSB/LSB boundaries.
- Frame ch0=0x8001 → data0=0x001, frame_err=1. Next frame ch0=0x0001 → frame_err=0.
- Pulse start again during SHIFT and QUIET → ignored; exactly one valid per accepted start; busy low only after QUIET_CYCLES=8 cycles of CS_n high.
- CONTINUOUS=1, SCLK_DIV=1, QUIET_CYCLES=1, no start → valid every 36 cycles with changing model data; all samples match.
- Assert rst at the 7th SCLK rising edge → CS_n=1, SCLK=1, valid never pulses, data0/1=0. After release, a start yields a correct frame.
